// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - ball physics step engine: wall/paddle collision, score, lose latch
module ball_engine #(
    parameter int CW        = 11,
    parameter int VW        = 4,
    parameter int X_MIN     = 10,
    parameter int X_MAX     = 629,
    parameter int Y_MIN     = 20,
    parameter int PADDLE_Y  = 459,
    parameter int START_X   = 20,
    parameter int START_Y   = 20,
    parameter int ZONES     = 7,
    parameter int ZONE_W    = 12,
    parameter int MAX_SPEED = 4,
    parameter int SCORE_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                serve,
    input  logic [CW-1:0]       paddle_left,
    output logic [CW-1:0]       ball_x,
    output logic [CW-1:0]       ball_y,
    output logic signed [VW-1:0] dx,
    output logic signed [VW-1:0] dy,
    output logic                busy,
    output logic                bounce,
    output logic [SCORE_W-1:0]  score,
    output logic                lose
);

    typedef enum logic [1:0] {IDLE, ADD, RESOLVE, LOST} state_t;

    localparam logic signed [CW:0] XMIN_S = (CW+1)'(X_MIN);
    localparam logic signed [CW:0] XMAX_S = (CW+1)'(X_MAX);
    localparam logic signed [CW:0] YMIN_S = (CW+1)'(Y_MIN);
    localparam logic signed [CW:0] PY_S   = (CW+1)'(PADDLE_Y);
    localparam logic signed [CW:0] SPAN_S = (CW+1)'(ZONES * ZONE_W);
    localparam logic signed [CW:0] HALF_S = (CW+1)'(ZONES / 2);
    localparam logic signed [CW:0] MAXS_S = (CW+1)'(MAX_SPEED);
    localparam logic [CW-1:0]      ZW_U   = CW'(ZONE_W);
    localparam logic [CW-1:0]      HALF_U = CW'(ZONES / 2);
    localparam logic signed [VW-1:0] HALF_V = VW'(ZONES / 2);
    localparam logic signed [VW-1:0] MAX_V  = VW'(MAX_SPEED);
    localparam logic signed [VW-1:0] ONE_V  = VW'(1);

    state_t state, state_next;
    logic signed [CW:0] cand_x, cand_y;
    logic               tick_q;

    logic signed [VW-1:0] abs_dx, abs_dy, ndx, ndy, zdx;
    logic [CW-1:0]        nx, ny, zone;
    logic signed [CW:0]   off, zrel;
    logic                 wall_hit, at_paddle, paddle_hit, miss;

    always_comb begin
        abs_dx   = dx[VW-1] ? -dx : dx;
        abs_dy   = dy[VW-1] ? -dy : dy;
        nx       = cand_x[CW-1:0];
        ny       = cand_y[CW-1:0];
        ndx      = dx;
        ndy      = dy;
        wall_hit = 1'b0;
        at_paddle = 1'b0;

        if (cand_x <= XMIN_S) begin
            nx       = CW'(X_MIN);
            ndx      = abs_dx;
            wall_hit = 1'b1;
        end else if (cand_x >= XMAX_S) begin
            nx       = CW'(X_MAX);
            ndx      = -abs_dx;
            wall_hit = 1'b1;
        end

        if (cand_y <= YMIN_S) begin
            ny       = CW'(Y_MIN);
            ndy      = abs_dy;
            wall_hit = 1'b1;
        end else if (cand_y >= PY_S) begin
            ny        = CW'(PADDLE_Y);
            at_paddle = 1'b1;
        end

        // Paddle offset uses the already-clamped column so a corner hit still scores.
        off        = $signed({1'b0, nx}) - $signed({1'b0, paddle_left});
        paddle_hit = at_paddle && !off[CW] && (off < SPAN_S);
        miss       = at_paddle && !paddle_hit;
        zone       = off[CW-1:0] / ZW_U;
        zrel       = $signed({1'b0, zone}) - HALF_S;
        if (zrel > MAXS_S)
            zdx = MAX_V;
        else if (zrel < -MAXS_S)
            zdx = -MAX_V;
        else
            zdx = $signed(zone[VW-1:0]) - HALF_V;

        if (paddle_hit) begin
            ndy = -abs_dy;
            if (zone != HALF_U)
                ndx = zdx;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE:    if (tick && !tick_q) state_next = ADD;
            ADD: begin
                busy       = 1'b1;
                state_next = RESOLVE;
            end
            RESOLVE: begin
                busy       = 1'b1;
                state_next = miss ? LOST : IDLE;
            end
            LOST:    if (serve) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tick is a request pulse: a level held high only starts one step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tick_q <= tick;
            ball_x <= CW'(START_X);
            ball_y <= CW'(START_Y);
            dx     <= ONE_V;
            dy     <= ONE_V;
            score  <= '0;
            lose   <= 1'b0;
            bounce <= 1'b0;
            cand_x <= '0;
            cand_y <= '0;
        end else begin
            state  <= state_next;
            tick_q <= tick;
            bounce <= 1'b0;
            case (state)
                ADD: begin
                    cand_x <= $signed({1'b0, ball_x}) + $signed({{(CW+1-VW){dx[VW-1]}}, dx});
                    cand_y <= $signed({1'b0, ball_y}) + $signed({{(CW+1-VW){dy[VW-1]}}, dy});
                end
                RESOLVE: begin
                    ball_x <= nx;
                    ball_y <= ny;
                    if (!miss) begin
                        dx <= ndx;
                        dy <= ndy;
                    end
                    bounce <= (wall_hit || paddle_hit) && !miss;
                    if (paddle_hit && (score != '1))
                        score <= score + 1'b1;
                    if (miss)
                        lose <= 1'b1;
                end
                LOST: begin
                    if (serve) begin
                        ball_x <= CW'(START_X);
                        ball_y <= CW'(START_Y);
                        dx     <= ONE_V;
                        dy     <= ONE_V;
                        lose   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Parametrised ball-physics engine for the pong display path. It advances the ball one step per frame tick using a signed per-axis velocity (dx, dy).
- Resolves collisions with the left, right and top walls and with a zoned paddle on the bottom row.
- Keeps a saturating score and latches a lose state.
- Its ball_x/ball_y outputs feed the sprite renderer; paddle_left comes from the paddle controller.

Parameters:
- CW, 11, coordinate width (unsigned positions); internal candidate math is CW+1 bits signed.
- VW, 4, velocity width, signed two's complement.
- X_MIN, 10, left wall column.
- X_MAX, 629, right wall column.
- Y_MIN, 20, top wall row.
- PADDLE_Y, 459, paddle contact row.
- START_X, 20, serve x.
- START_Y, 20, serve y.
- ZONES, 7, number of paddle zones (odd).
- ZONE_W, 12, pixels per zone.
- MAX_SPEED, 4, clamp on |dx|.
- SCORE_W, 8, score width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- tick  in  1  frame-step request pulse
- serve  in  1  restart ball after a loss
- paddle_left  in  CW  leftmost paddle column
- ball_x  out  CW  ball column
- ball_y  out  CW  ball row
- dx  out  VW  signed x velocity
- dy  out  VW  signed y velocity
- busy  out  1  step in progress
- bounce  out  1  one-cycle pulse on any collision
- score  out  SCORE_W  paddle hits
- lose  out  1  ball missed paddle

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values: ball_x=START_X, ball_y=START_Y, dx=+1, dy=+1, score=0, lose=0, bounce=0, busy=0, state IDLE. Reset wins over all other inputs, including mid-step; a partially computed step is discarded.
- States:
  - IDLE: tick=1 -> ADD.
  - ADD: register cand_x=ball_x+dx, cand_y=ball_y+dy (signed, CW+1 bits) -> RESOLVE.
  - RESOLVE: apply the rules below -> IDLE, or LOST on a miss.
  - LOST: tick ignored; serve=1 -> ball_x/ball_y=START, dx=+1, dy=+1, lose=0 -> IDLE. Score is kept.
- Timing: busy=1 in ADD and RESOLVE. New position is visible 3 cycles after the cycle tick is sampled high.
- tick outside IDLE is dropped. serve outside LOST is ignored.
- RESOLVE rules (x and y evaluated independently; a corner reflects both axes, one bounce pulse):
  - cand_x<=X_MIN: ball_x=X_MIN, dx=|dx|.
  - cand_x>=X_MAX: ball_x=X_MAX, dx=-|dx|.
  - Otherwise ball_x=cand_x.
  - cand_y<=Y_MIN: ball_y=Y_MIN, dy=|dy|.
  - cand_y>=PADDLE_Y: ball_y=PADDLE_Y, then do the paddle test.
  - Otherwise ball_y=cand_y.
- Paddle test: off = clamped_x - paddle_left (signed). Hit iff 0<=off<ZONES*ZONE_W.
  - zone = off/ZONE_W.
  - Hit: dy=-|dy|; score+1, saturating at all-ones.
  - Hit, zone==ZONES/2: dx unchanged.
  - Hit, otherwise: dx = zone-ZONES/2, clamped to ±MAX_SPEED.
  - Miss: lose=1, state LOST, dx/dy hold.
- bounce=1 for exactly the cycle after RESOLVE when any wall or paddle reflection occurred. A miss does not pulse bounce.
- dx is never set to 0 by a wall reflection. Velocity magnitudes are never altered by walls.

Test Plan:
- Reset with tick=1 held -> ball_x=20, ball_y=20, dx=+1, dy=+1, score=0, lose=0, busy=0.
- Single tick -> busy high 2 cycles; 3 cycles after tick, ball=(21,21); bounce=0. Ticks on 4 consecutive cycles -> one step only.
- paddle_left=420, 439 ticks -> ball=(459,459), zone 3, dx=+1, dy=-1, score=1, bounce pulse. Then 170 ticks -> ball=(629,289), dx=-1, bounce pulse.
- paddle_left=448, 439 ticks -> off=11, zone 0, dx=-3, dy=-1, score=1.
- paddle_left=0, 439 ticks -> lose=1, ball=(459,459), further ticks ignored. serve -> (20,20), dx=dy=+1, lose=0, score unchanged.
- Assert reset during ADD -> next cycle all outputs at reset values, state IDLE. Score preloaded to 255 by 255 hits, then a hit -> stays 255.
